fifo_write_arbiter: RTL and testbench

//  Shares one FIFO write port (din/input_valid/input_ready) between N_REQ producers.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_write_arbiter_rr_priority_select.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional statistics counters are enabled with FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

   typedef enum logic {
      ARB_IDLE,
      ARB_LOCKED
   } arb_state_t;

   function automatic int unsigned wrap_inc(
      input int unsigned ptr,
      input int unsigned n
   );
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_select.sv
// Find-first-set search over a request vector, starting at a rotating pointer.
module rr_priority_select #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic                 found,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   logic [N-1:0]  rot;
   logic [IW-1:0] off;
   logic [IW:0]   sum;

   always_comb begin
      // rot[0] corresponds to req[ptr]
      rot = (req >> ptr) | (req << (N - int'(ptr)));
      found = |rot;
      off = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) off = IW'(k);
      end
      sum = {1'b0, ptr} + {1'b0, off};
      if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
      idx = sum[IW-1:0];
   end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-requester accepted-beat counters.
module fifo_write_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                            clk,
   input  logic                            arst_in,
   input  logic [N_REQ-1:0][WIDTH-1:0]     req_data,
   input  logic [N_REQ-1:0]                req_valid,
   output logic [N_REQ-1:0]                req_ready,
   output logic [WIDTH-1:0]                fifo_din,
   output logic                            fifo_input_valid,
   input  logic                            fifo_input_ready,
   output logic [$clog2(N_REQ)-1:0]        grant_id,
`ifdef FIFO_ARB_STATS_EN
   input  logic                            stat_clear,
   output logic [N_REQ-1:0][CNT_WIDTH-1:0] stat_count,
`endif
   output logic                            busy
);

   localparam int IW = $clog2(N_REQ);
   localparam int BW = $clog2(MAX_BURST + 1);

   if (N_REQ < 2 || MAX_BURST < 1 || CNT_WIDTH < 1) begin : g_param_chk
      $error("fifo_write_arbiter: illegal parameter set");
   end

   arb_state_t    state_q, state_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [BW-1:0] beats_q, beats_d;
   logic [BW-1:0] beats_inc;

   logic          sel_found;
   logic [IW-1:0] sel_idx;
   logic          xfer;

   rr_priority_select #(
      .N (N_REQ)
   ) u_sel (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .found (sel_found),
      .idx   (sel_idx)
   );

   // Outputs are forced quiet while reset is asserted
   always_comb begin
      grant_id = '0;
      if (state_q == ARB_LOCKED) grant_id = owner_q;
      else if (sel_found) grant_id = sel_idx;
      if (arst_in) grant_id = '0;
      fifo_din = req_data[grant_id];
      fifo_input_valid = !arst_in && req_valid[grant_id];
      req_ready = '0;
      if (fifo_input_ready && !arst_in) begin
         req_ready = {{(N_REQ - 1){1'b0}}, 1'b1} << grant_id;
      end
      xfer = fifo_input_valid && fifo_input_ready;
      busy = (state_q == ARB_LOCKED) || (|req_valid);
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_ptr_d = rr_ptr_q;
      beats_d = beats_q;
      beats_inc = beats_q + BW'(1);
      unique case (state_q)
         ARB_IDLE: begin
            if (sel_found) begin
               if (xfer && MAX_BURST == 1) begin
                  rr_ptr_d = IW'(wrap_inc(32'(sel_idx), N_REQ));
               end else begin
                  state_d = ARB_LOCKED;
                  owner_d = sel_idx;
                  beats_d = xfer ? BW'(1) : '0;
               end
            end
         end
         ARB_LOCKED: begin
            if (!req_valid[owner_q]) begin
               state_d = ARB_IDLE;
               rr_ptr_d = IW'(wrap_inc(32'(owner_q), N_REQ));
               beats_d = '0;
            end else if (xfer) begin
               if (beats_inc == BW'(MAX_BURST)) begin
                  state_d = ARB_IDLE;
                  rr_ptr_d = IW'(wrap_inc(32'(owner_q), N_REQ));
                  beats_d = '0;
               end else begin
                  beats_d = beats_inc;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         rr_ptr_q <= '0;
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         beats_q <= beats_d;
      end
   end

`ifdef FIFO_ARB_STATS_EN
   logic [N_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Clear has priority; counters saturate at all-ones
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < N_REQ; i++) begin
         if (stat_clear) begin
            cnt_d[i] = '0;
         end else if (xfer && grant_id == IW'(i) && cnt_q[i] != '1) begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end

   assign stat_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed, table-driven bench for fifo_write_arbiter.
module tb_fifo_write_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int MB = 4;
   localparam int CW = 4;

   logic                clk = 1'b0;
   logic                arst_in;
   logic [N-1:0][W-1:0] req_data;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [W-1:0]        fifo_din;
   logic                fifo_input_valid;
   logic                fifo_input_ready;
   logic [1:0]          grant_id;
   logic                busy;
`ifdef FIFO_ARB_STATS_EN
   logic                stat_clear;
   logic [N-1:0][CW-1:0] stat_count;
`endif

   fifo_write_arbiter #(
      .N_REQ     (N),
      .WIDTH     (W),
      .MAX_BURST (MB),
      .CNT_WIDTH (CW)
   ) dut (
      .clk              (clk),
      .arst_in          (arst_in),
      .req_data         (req_data),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .fifo_din         (fifo_din),
      .fifo_input_valid (fifo_input_valid),
      .fifo_input_ready (fifo_input_ready),
      .grant_id         (grant_id),
`ifdef FIFO_ARB_STATS_EN
      .stat_clear       (stat_clear),
      .stat_count       (stat_count),
`endif
      .busy             (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] v;
      logic       rdy;
      logic       ev;
      logic [1:0] eg;
      logic [3:0] er;
      logic       eb;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] v, input logic rdy, input logic ev,
                      input logic [1:0] eg, input logic [3:0] er,
                      input logic eb);
      vec_t t;
      t.v = v; t.rdy = rdy; t.ev = ev; t.eg = eg; t.er = er; t.eb = eb;
      tbl.push_back(t);
   endtask

   task automatic set_data(input int tag);
      for (int j = 0; j < N; j++) req_data[j] = {8'(j), 24'(tag)};
   endtask

   initial begin
      arst_in = 1'b1;
      req_valid = 4'b1111;
      fifo_input_ready = 1'b1;
      set_data(0);
`ifdef FIFO_ARB_STATS_EN
      stat_clear = 1'b0;
`endif

      // all valid during reset, then 0x4, 1x4, 2x4, 3x4, 0 again
      for (int k = 0; k < 16; k++)
         add(4'b1111, 1, 1, 2'(k / 4), 4'(1 << (k / 4)), 1);
      add(4'b1111, 1, 1, 0, 4'b0001, 1);
      add(4'b0000, 1, 0, 0, 4'b0001, 1);
      add(4'b0000, 1, 0, 0, 4'b0001, 0);
      // single requester, back-to-back bursts with no bubble
      for (int k = 0; k < 6; k++) add(4'b0100, 1, 1, 2, 4'b0100, 1);
      add(4'b0000, 1, 0, 2, 4'b0100, 1);
      add(4'b0000, 1, 0, 0, 4'b0001, 0);
      // stall mid-burst; stalled cycles are not counted
      add(4'b0010, 1, 1, 1, 4'b0010, 1);
      add(4'b0010, 1, 1, 1, 4'b0010, 1);
      for (int k = 0; k < 3; k++) add(4'b0010, 0, 1, 1, 4'b0000, 1);
      add(4'b0010, 1, 1, 1, 4'b0010, 1);
      add(4'b0010, 1, 1, 1, 4'b0010, 1);
      add(4'b0110, 1, 1, 2, 4'b0100, 1);
      add(4'b0000, 1, 0, 2, 4'b0100, 1);
      // owner drops valid: one bubble, then search restarts at 0
      add(4'b1010, 1, 1, 3, 4'b1000, 1);
      add(4'b0010, 1, 0, 3, 4'b1000, 1);
      add(4'b0010, 1, 1, 1, 4'b0010, 1);
      // stall on first beat still locks the owner
      add(4'b0000, 1, 0, 1, 4'b0010, 1);
      add(4'b0001, 0, 1, 0, 4'b0000, 1);
      add(4'b1001, 0, 1, 0, 4'b0000, 1);
      add(4'b1001, 1, 1, 0, 4'b0001, 1);

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst req_ready", 64'(req_ready), 64'(0));
      chk("rst fifo_valid", 64'(fifo_input_valid), 64'(0));
      chk("rst grant_id", 64'(grant_id), 64'(0));
      arst_in = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         req_valid = tbl[i].v;
         fifo_input_ready = tbl[i].rdy;
         set_data(i);
         #1;
         chk($sformatf("v%0d valid", i), 64'(fifo_input_valid),
             64'(tbl[i].ev));
         chk($sformatf("v%0d grant", i), 64'(grant_id), 64'(tbl[i].eg));
         chk($sformatf("v%0d ready", i), 64'(req_ready), 64'(tbl[i].er));
         chk($sformatf("v%0d busy", i), 64'(busy), 64'(tbl[i].eb));
         chk($sformatf("v%0d din", i), 64'(fifo_din),
             64'({8'(tbl[i].eg), 24'(i)}));
         chk($sformatf("v%0d onehot", i), 64'($countones(req_ready) <= 1),
             64'(1));
         @(negedge clk);
      end

      // mid-operation reset while owner 0 is locked
      req_valid = 4'b1001;
      fifo_input_ready = 1'b1;
      #1;
      arst_in = 1'b1;
      #1;
      chk("midrst ready", 64'(req_ready), 64'(0));
      chk("midrst valid", 64'(fifo_input_valid), 64'(0));
      chk("midrst grant", 64'(grant_id), 64'(0));
      @(negedge clk);
      arst_in = 1'b0;
      req_valid = 4'b1000;
      #1;
      chk("postrst grant", 64'(grant_id), 64'(3));
      chk("postrst valid", 64'(fifo_input_valid), 64'(1));

`ifdef FIFO_ARB_STATS_EN
      @(negedge clk);
      req_valid = 4'b0000;
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      #1;
      for (int j = 0; j < N; j++)
         chk($sformatf("clr0 cnt%0d", j), 64'(stat_count[j]), 64'(0));
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         req_valid = 4'b0010;
      end
      @(negedge clk);
      stat_clear = 1'b1;
      #1;
      for (int j = 0; j < N; j++)
         chk($sformatf("sat cnt%0d", j), 64'(stat_count[j]),
             64'(j == 1 ? 15 : 0));
      @(negedge clk);
      stat_clear = 1'b0;
      req_valid = 4'b0000;
      #1;
      chk("clr1 cnt1", 64'(stat_count[1]), 64'(0));
`endif

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
